app_to_fifo: RTL and testbench

- Read-return path of the DDR2 memory interface. Mirror of fifo_to_app.
- Tracks read commands accepted by the DDR controller and captures 64-bit app_rd_data beats. Each pair of beats becomes one 128-bit word.
- Tags each word with the address of its command and presents it to the read-return consumer through the has/get strobe interface.
- Generates a credit signal so fifo_to_app never issues more reads than this block can buffer.

---
 rtl/ddr_if_pkg.sv | 15 +
 rtl/sync_fifo_fwft.sv | 63 ++++++
 rtl/app_to_fifo.sv | 171 +++++++++++++++++
 tb/tb_app_to_fifo.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_if_pkg.sv
// rtl/ddr_if_pkg.sv - shared DDR2 app-interface constants and types
package ddr_if_pkg;

  localparam int ADX_W = 27;
  localparam int APP_W = 64;

  localparam logic [2:0] CMD_READ  = 3'b001;
  localparam logic [2:0] CMD_WRITE = 3'b000;

  typedef enum logic {
    BEAT_LO,
    BEAT_HI
  } beat_state_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// rtl/sync_fifo_fwft.sv - synchronous first-word-fall-through FIFO with occupancy count
module sync_fifo_fwft #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A full FIFO still takes a push when the same cycle frees a slot.
  assign do_push = push & (~full | do_pop);
  assign count   = count_q;
  // Empty FIFO presents zero rather than stale storage.
  assign head    = empty ? '0 : mem_q[rd_ptr_q];

  // Next pointer and occupancy from the accepted push/pop pair.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop)      count_d = count_q + CW'(1);
    else if (!do_push && do_pop) count_d = count_q - CW'(1);
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents need no reset since head is gated by empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/app_to_fifo.sv
// rtl/app_to_fifo.sv - DDR2 read-return path: beat pairing, address tagging, credit (optional APP_TO_FIFO_STATS_EN)
module app_to_fifo #(
  parameter int DEPTH = 16,
  parameter int ADX_W = ddr_if_pkg::ADX_W,
  parameter int APP_W = ddr_if_pkg::APP_W,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_issued,
  input  logic [ADX_W-1:0]   cmd_adx,
  input  logic [APP_W-1:0]   app_rd_data,
  input  logic               app_rd_data_valid,
  input  logic               app_rd_data_end,
  output logic               has_rd_data,
  input  logic               get_rd_data,
  output logic [2*APP_W-1:0] rd_data_out,
  output logic [ADX_W-1:0]   rd_adx_out,
  output logic               rd_credit_ok,
  output logic               err_overflow,
  output logic               err_unexpected,
  output logic               err_end
`ifdef APP_TO_FIFO_STATS_EN
  ,
  output logic [31:0]        stat_words,
  output logic [CW-1:0]      stat_max_out
`endif
);

  import ddr_if_pkg::*;

  localparam int DW = ADX_W + 2 * APP_W;
  localparam int SW = CW + 1;

  beat_state_t      state_q, state_d;
  logic [APP_W-1:0] lo_q, lo_d;
  logic             err_overflow_q, err_overflow_d;
  logic             err_unexpected_q, err_unexpected_d;
  logic             err_end_q, err_end_d;

  logic             tag_pop, tag_full, tag_empty;
  logic [CW-1:0]    tag_count;
  logic [ADX_W-1:0] tag_head;

  logic             data_push, data_pop, data_full, data_empty;
  logic [CW-1:0]    data_count;
  logic [DW-1:0]    data_head;

  logic             tag_ovf, data_ovf;
  logic [SW-1:0]    occupancy;

  sync_fifo_fwft #(.WIDTH(ADX_W), .DEPTH(DEPTH)) u_tag_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (cmd_issued),
    .push_data (cmd_adx),
    .pop       (tag_pop),
    .full      (tag_full),
    .empty     (tag_empty),
    .count     (tag_count),
    .head      (tag_head)
  );

  // Stored word layout: {address, second beat, first beat}.
  sync_fifo_fwft #(.WIDTH(DW), .DEPTH(DEPTH)) u_data_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (data_push),
    .push_data ({tag_head, app_rd_data, lo_q}),
    .pop       (data_pop),
    .full      (data_full),
    .empty     (data_empty),
    .count     (data_count),
    .head      (data_head)
  );

  assign data_pop     = get_rd_data & ~data_empty;
  assign tag_ovf      = cmd_issued & tag_full & ~tag_pop;
  assign data_ovf     = data_push & data_full & ~data_pop;

  assign has_rd_data  = ~data_empty;
  assign rd_data_out  = data_head[2*APP_W-1:0];
  assign rd_adx_out   = data_head[DW-1:2*APP_W];

  // A half-assembled word counts against the credit as it will occupy a data slot.
  assign occupancy    = SW'(tag_count) + SW'(data_count) + SW'(state_q == BEAT_HI);
  assign rd_credit_ok = (occupancy < SW'(DEPTH));

  assign err_overflow   = err_overflow_q;
  assign err_unexpected = err_unexpected_q;
  assign err_end        = err_end_q;

  // Beat pairing FSM plus sticky error accumulation.
  always_comb begin
    state_d          = state_q;
    lo_d             = lo_q;
    tag_pop          = 1'b0;
    data_push        = 1'b0;
    err_overflow_d   = err_overflow_q | tag_ovf | data_ovf;
    err_unexpected_d = err_unexpected_q;
    err_end_d        = err_end_q;
    if (app_rd_data_valid) begin
      case (state_q)
        BEAT_LO: begin
          lo_d    = app_rd_data;
          state_d = BEAT_HI;
          if (app_rd_data_end) err_end_d = 1'b1;
          // A tag arriving in the same cycle as the first beat is legal.
          if (tag_empty && !cmd_issued) err_unexpected_d = 1'b1;
        end
        BEAT_HI: begin
          data_push = 1'b1;
          tag_pop   = ~tag_empty;
          state_d   = BEAT_LO;
          if (!app_rd_data_end) err_end_d = 1'b1;
          if (tag_empty) err_unexpected_d = 1'b1;
        end
        default: state_d = BEAT_LO;
      endcase
    end
  end

  // FSM, low-beat holding register and error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= BEAT_LO;
      lo_q             <= '0;
      err_overflow_q   <= 1'b0;
      err_unexpected_q <= 1'b0;
      err_end_q        <= 1'b0;
    end else begin
      state_q          <= state_d;
      lo_q             <= lo_d;
      err_overflow_q   <= err_overflow_d;
      err_unexpected_q <= err_unexpected_d;
      err_end_q        <= err_end_d;
    end
  end

`ifdef APP_TO_FIFO_STATS_EN
  logic [31:0]   stat_words_q, stat_words_d;
  logic [CW-1:0] stat_max_q, stat_max_d;
  logic [SW-1:0] pair_occ;
  logic [CW-1:0] pair_occ_sat;

  assign pair_occ     = SW'(tag_count) + SW'(data_count);
  assign pair_occ_sat = pair_occ[SW-1] ? '1 : pair_occ[CW-1:0];
  assign stat_words   = stat_words_q;
  assign stat_max_out = stat_max_q;

  // Accepted-word counter and occupancy high-water mark.
  always_comb begin
    stat_words_d = stat_words_q;
    stat_max_d   = stat_max_q;
    if (data_push && !data_ovf) stat_words_d = stat_words_q + 32'd1;
    if (pair_occ_sat > stat_max_q) stat_max_d = pair_occ_sat;
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_words_q <= '0;
      stat_max_q   <= '0;
    end else begin
      stat_words_q <= stat_words_d;
      stat_max_q   <= stat_max_d;
    end
  end
`endif

endmodule

// File: tb/tb_app_to_fifo.sv
// tb/tb_app_to_fifo.sv - self-checking bench for app_to_fifo
module tb_app_to_fifo;

  localparam int D  = 16;
  localparam int AW = 27;
  localparam int PW = 64;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_issued = 1'b0;
  logic [AW-1:0] cmd_adx = '0;
  logic [PW-1:0] app_rd_data = '0;
  logic          app_rd_data_valid = 1'b0;
  logic          app_rd_data_end = 1'b0;
  logic          get_rd_data = 1'b0;
  logic          has_rd_data;
  logic [2*PW-1:0] rd_data_out;
  logic [AW-1:0] rd_adx_out;
  logic          rd_credit_ok, err_overflow, err_unexpected, err_end;
`ifdef APP_TO_FIFO_STATS_EN
  logic [31:0]   stat_words;
  logic [4:0]    stat_max_out;
`endif

  app_to_fifo #(.DEPTH(D), .ADX_W(AW), .APP_W(PW)) dut (
    .clk               (clk),
    .reset             (reset),
    .cmd_issued        (cmd_issued),
    .cmd_adx           (cmd_adx),
    .app_rd_data       (app_rd_data),
    .app_rd_data_valid (app_rd_data_valid),
    .app_rd_data_end   (app_rd_data_end),
    .has_rd_data       (has_rd_data),
    .get_rd_data       (get_rd_data),
    .rd_data_out       (rd_data_out),
    .rd_adx_out        (rd_adx_out),
    .rd_credit_ok      (rd_credit_ok),
    .err_overflow      (err_overflow),
    .err_unexpected    (err_unexpected),
    .err_end           (err_end)
`ifdef APP_TO_FIFO_STATS_EN
    ,
    .stat_words        (stat_words),
    .stat_max_out      (stat_max_out)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: outstanding tags, buffered words {adx, hi, lo}, pending low beat.
  logic [AW-1:0]        m_tag [$];
  logic [AW+2*PW-1:0]   m_word [$];
  bit                   m_half;
  logic [PW-1:0]        m_lo;
  bit                   m_ovf, m_unexp, m_end;

  typedef struct {
    bit            cmd;
    logic [AW-1:0] adx;
    bit            v;
    logic [PW-1:0] d;
    bit            e;
    bit            g;
    bit            x_has;
    logic [127:0]  x_data;
    logic [AW-1:0] x_adx;
    bit            x_cr;
    logic [2:0]    x_err;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic check_all();
    bit            has;
    logic [127:0]  xd;
    logic [AW-1:0] xa;
    int            occ;
    has = (m_word.size() > 0);
    xd  = has ? m_word[0][127:0] : '0;
    xa  = has ? m_word[0][AW+127:128] : '0;
    occ = m_tag.size() + m_word.size() + int'(m_half);
    chk("has_rd_data", has_rd_data, has);
    chk("rd_data_out", rd_data_out, xd);
    chk("rd_adx_out", rd_adx_out, xa);
    chk("rd_credit_ok", rd_credit_ok, occ < D);
    chk("err_flags", {err_overflow, err_unexpected, err_end}, {m_ovf, m_unexp, m_end});
  endtask

  task automatic drive(input bit c, input logic [AW-1:0] a, input bit v,
                       input logic [PW-1:0] d, input bit e, input bit g);
    cmd_issued = c; cmd_adx = a; app_rd_data_valid = v;
    app_rd_data = d; app_rd_data_end = e; get_rd_data = g;
  endtask

  task automatic reset_dut();
    drive(0, '0, 0, '0, 0, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    m_tag.delete(); m_word.delete();
    m_half = 0; m_lo = '0; m_ovf = 0; m_unexp = 0; m_end = 0;
    check_all();
  endtask

  // One clock with the given inputs; the model applies the read-return rules.
  task automatic step(input bit c, input logic [AW-1:0] a, input bit v,
                      input logic [PW-1:0] d, input bit e, input bit g);
    int nt, nw;
    bit pop_w, pop_t, push_w;
    logic [AW-1:0] ta;
    logic [AW+2*PW-1:0] w;
    drive(c, a, v, d, e, g);
    nt = m_tag.size(); nw = m_word.size();
    pop_w = g && (nw > 0); pop_t = 0; push_w = 0; w = '0;
    if (v) begin
      if (!m_half) begin
        if (nt == 0 && !c) m_unexp = 1;
        if (e) m_end = 1;
        m_lo = d; m_half = 1;
      end else begin
        push_w = 1;
        if (nt == 0) m_unexp = 1; else pop_t = 1;
        ta = (nt > 0) ? m_tag[0] : '0;
        w = {ta, d, m_lo};
        if (!e) m_end = 1;
        m_half = 0;
      end
    end
    if (pop_w) void'(m_word.pop_front());
    if (push_w) begin
      if (nw == D && !pop_w) m_ovf = 1; else m_word.push_back(w);
    end
    if (pop_t) void'(m_tag.pop_front());
    if (c) begin
      if (nt == D && !pop_t) m_ovf = 1; else m_tag.push_back(a);
    end
    @(posedge clk); #1;
    check_all();
  endtask

  initial begin
    tbl[0] = '{1, 27'h100, 0, 64'h0,    0, 0, 0, 128'h0, 27'h0, 1, 3'b000};
    tbl[1] = '{0, 27'h0,   1, 64'h1111, 0, 0, 0, 128'h0, 27'h0, 1, 3'b000};
    tbl[2] = '{0, 27'h0,   1, 64'h2222, 1, 0, 1, {64'h2222, 64'h1111}, 27'h100, 1, 3'b000};
    tbl[3] = '{0, 27'h0,   0, 64'h0,    0, 1, 0, 128'h0, 27'h0, 1, 3'b000};
    tbl[4] = '{0, 27'h0,   0, 64'h0,    0, 1, 0, 128'h0, 27'h0, 1, 3'b000};
    tbl[5] = '{0, 27'h0,   1, 64'h33,   0, 0, 0, 128'h0, 27'h0, 1, 3'b010};
    tbl[6] = '{0, 27'h0,   1, 64'h44,   1, 0, 1, {64'h44, 64'h33}, 27'h0, 1, 3'b010};
    tbl[7] = '{0, 27'h0,   0, 64'h0,    0, 1, 0, 128'h0, 27'h0, 1, 3'b010};

    reset_dut();

    // Single read, get-while-empty, then an unexpected beat pair.
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].cmd, tbl[i].adx, tbl[i].v, tbl[i].d, tbl[i].e, tbl[i].g);
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_has", i), has_rd_data, tbl[i].x_has);
      chk($sformatf("tbl%0d_data", i), rd_data_out, tbl[i].x_data);
      chk($sformatf("tbl%0d_adx", i), rd_adx_out, tbl[i].x_adx);
      chk($sformatf("tbl%0d_credit", i), rd_credit_ok, tbl[i].x_cr);
      chk($sformatf("tbl%0d_err", i), {err_overflow, err_unexpected, err_end}, tbl[i].x_err);
    end

    // First beat flagged as end.
    reset_dut();
    step(1, 27'h5, 0, '0, 0, 0);
    step(0, '0, 1, 64'hAB, 1, 0);
    step(0, '0, 1, 64'hCD, 1, 0);
    step(0, '0, 0, '0, 0, 1);
    step(0, '0, 0, '0, 0, 0);
    chk("err_end_sticky", err_end, 1'b1);

    // Credit limit.
    reset_dut();
    for (int i = 0; i < D; i++) step(1, AW'(i * 3), 0, '0, 0, 0);
    chk("credit_exhausted", rd_credit_ok, 1'b0);
    step(0, '0, 1, 64'hA0, 0, 0);
    step(0, '0, 1, 64'hA1, 1, 0);
    chk("credit_word_buffered", rd_credit_ok, 1'b0);
    step(0, '0, 0, '0, 0, 1);
    chk("credit_restored", rd_credit_ok, 1'b1);

    // Back-to-back four reads with continuous pop.
    reset_dut();
    for (int i = 0; i < 4; i++) step(1, AW'(i * 16), 0, '0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, '0, 1, PW'(64'hB000 + i), i[0], 1);
    for (int i = 0; i < 3; i++) step(0, '0, 0, '0, 0, 1);
    chk("b2b_no_errors", {err_overflow, err_unexpected, err_end}, 3'b000);

    // Full data FIFO: push with simultaneous pop, then without.
    reset_dut();
    for (int i = 0; i < D; i++) step(1, AW'(i), 0, '0, 0, 0);
    for (int i = 0; i < 2 * D; i++) step(0, '0, 1, PW'(64'hC000 + i), i[0], 0);
    step(1, 27'h77, 1, 64'hD0, 0, 0);
    step(0, '0, 1, 64'hD1, 1, 1);
    chk("full_push_pop_no_ovf", err_overflow, 1'b0);
    step(1, 27'h78, 1, 64'hE0, 0, 0);
    step(0, '0, 1, 64'hE1, 1, 0);
    chk("full_push_ovf", err_overflow, 1'b1);

    // Reset mid-burst with tags outstanding, then a clean read.
    reset_dut();
    for (int i = 0; i < 3; i++) step(1, AW'(i + 40), 0, '0, 0, 0);
    step(0, '0, 1, 64'hF0, 0, 0);
    reset_dut();
    chk("midburst_credit", rd_credit_ok, 1'b1);
    step(1, 27'h123, 0, '0, 0, 0);
    step(0, '0, 1, 64'h5555, 0, 0);
    step(0, '0, 1, 64'h6666, 1, 0);
    chk("post_reset_word", rd_data_out, {64'h6666, 64'h5555});
    step(0, '0, 0, '0, 0, 1);

    // Randomised traffic against the model.
    reset_dut();
    for (int i = 0; i < 600; i++) begin
      bit c, v, e, g;
      c = ($urandom_range(2) == 0) &&
          ((m_tag.size() + m_word.size() + int'(m_half)) < D);
      v = ((m_half || m_tag.size() > 0) && $urandom_range(1) == 0) ||
          ($urandom_range(63) == 0);
      e = m_half ^ ($urandom_range(31) == 0);
      g = ($urandom_range(1) == 0);
      step(c, AW'($urandom), v, {$urandom, $urandom}, e, g);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
